// File: rtl/alu_bit_16.sv
// 16-bit two-stage pipelined ALU: stage 1 registers operands/opcode,
// stage 2 computes and registers result, remainder and carry_out.
module alu_bit_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [3:0]  shamt,
  input  logic [3:0]  sel,
  input  logic        cin,
  output logic [31:0] result,
  output logic [15:0] remainder,
  output logic        carry_out
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_DIV = 4'd3,
    OP_LSL = 4'd4,  OP_LSR = 4'd5,  OP_ROL = 4'd6,  OP_ROR = 4'd7,
    OP_INC = 4'd8,  OP_DEC = 4'd9,  OP_AND = 4'd10, OP_OR  = 4'd11,
    OP_XOR = 4'd12, OP_NOT = 4'd13, OP_RS0 = 4'd14, OP_RS1 = 4'd15
  } op_e;

  logic [15:0] A_r, B_r;
  logic [3:0]  shamt_r;
  op_e         sel_r;
  logic        cin_r;

  logic [31:0] w_result;
  logic [15:0] w_rem;
  logic        w_carry;
  logic [16:0] w_sh17;
  logic [31:0] w_rot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A_r     <= '0;
      B_r     <= '0;
      shamt_r <= '0;
      sel_r   <= OP_ADD;
      cin_r   <= 1'b0;
    end else begin
      A_r     <= A;
      B_r     <= B;
      shamt_r <= shamt;
      sel_r   <= op_e'(sel);
      cin_r   <= cin;
    end
  end

  always_comb begin
    w_result = '0;
    w_rem    = '0;
    w_carry  = 1'b0;
    w_sh17   = '0;
    w_rot    = '0;
    case (sel_r)
      OP_ADD: {w_carry, w_result[15:0]} = {1'b0, A_r} + {1'b0, B_r} + {16'b0, cin_r};
      OP_SUB: {w_carry, w_result[15:0]} = {1'b0, A_r} + {1'b0, ~B_r} + {16'b0, cin_r};
      OP_MUL: w_result = {16'b0, A_r} * {16'b0, B_r};
      OP_DIV: begin
        if (B_r != 16'd0) begin
          w_result[15:0] = A_r / B_r;
          w_rem          = A_r % B_r;
        end else begin
          w_result[15:0] = 16'hFFFF;
          w_rem          = A_r;
          w_carry        = 1'b1;
        end
      end
      // A 17-bit window keeps the last bit shifted out in the spare position
      OP_LSL: begin
        w_sh17         = {1'b0, A_r} << shamt_r;
        w_result[15:0] = w_sh17[15:0];
        w_carry        = w_sh17[16];
      end
      OP_LSR: begin
        w_sh17         = {A_r, 1'b0} >> shamt_r;
        w_result[15:0] = w_sh17[16:1];
        w_carry        = w_sh17[0];
      end
      OP_ROL: begin
        w_rot          = {A_r, A_r} << shamt_r;
        w_result[15:0] = w_rot[31:16];
      end
      OP_ROR: begin
        w_rot          = {A_r, A_r} >> shamt_r;
        w_result[15:0] = w_rot[15:0];
      end
      OP_INC: {w_carry, w_result[15:0]} = {1'b0, A_r} + 17'd1;
      OP_DEC: {w_carry, w_result[15:0]} = {1'b0, A_r} + 17'h0FFFF;
      OP_AND: w_result[15:0] = A_r & B_r;
      OP_OR:  w_result[15:0] = A_r | B_r;
      OP_XOR: w_result[15:0] = A_r ^ B_r;
      OP_NOT: w_result[15:0] = ~A_r;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      remainder <= '0;
      carry_out <= 1'b0;
    end else begin
      result    <= w_result;
      remainder <= w_rem;
      carry_out <= w_carry;
    end
  end

endmodule

// File: tb/tb_alu_bit_16.sv
// Self-checking bench for alu_bit_16: directed cases per opcode group,
// back-to-back issue, and randomized ops against an arithmetic reference.
module tb_alu_bit_16;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A, B;
  logic [3:0]  shamt, sel;
  logic        cin;
  logic [31:0] result;
  logic [15:0] remainder;
  logic        carry_out;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_bit_16 dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .shamt(shamt), .sel(sel), .cin(cin),
    .result(result), .remainder(remainder), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  // Reference computed straight from the opcode definitions with wide integers
  function automatic void model(input int unsigned a, input int unsigned b,
                                input int unsigned sh, input int unsigned op,
                                input int unsigned ci, output logic [48:0] exp_v);
    longint unsigned r;
    int unsigned rm, c, s;
    r = 0; rm = 0; c = 0;
    case (op)
      0: begin s = a + b + ci; r = s & 32'hFFFF; c = (s >> 16) & 1; end
      1: begin s = a + ((~b) & 32'hFFFF) + ci; r = s & 32'hFFFF; c = (s >> 16) & 1; end
      2: r = longint'(a) * longint'(b);
      3: if (b == 0) begin r = 16'hFFFF; rm = a; c = 1; end
         else begin r = a / b; rm = a % b; end
      4: begin r = (a << sh) & 32'hFFFF; c = (sh == 0) ? 0 : (a >> (16 - sh)) & 1; end
      5: begin r = a >> sh; c = (sh == 0) ? 0 : (a >> (sh - 1)) & 1; end
      6: r = ((a << sh) | (a >> (16 - sh))) & 32'hFFFF;
      7: r = ((a >> sh) | (a << (16 - sh))) & 32'hFFFF;
      8: begin s = a + 1; r = s & 32'hFFFF; c = (s >> 16) & 1; end
      9: begin s = a + 32'hFFFF; r = s & 32'hFFFF; c = (s >> 16) & 1; end
      10: r = a & b;
      11: r = a | b;
      12: r = a ^ b;
      13: r = (~a) & 32'hFFFF;
      default: ;
    endcase
    exp_v = {c[0], rm[15:0], r[31:0]};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh,
                       input logic [3:0] op, input logic ci);
    A = a; B = b; shamt = sh; sel = op; cin = ci;
  endtask

  // One op, then idle (reserved opcode); returns #1 after the output edge
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh,
                       input logic [3:0] op, input logic ci);
    drive(a, b, sh, op, ci);
    @(posedge clk); #1;
    drive(16'h0, 16'h0, 4'h0, 4'd15, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(16'h0, 16'h0, 4'h0, 4'd15, 1'b0);
    #3;
    n_cmp++;
    if ({carry_out, remainder, result} !== 49'd0) begin
      n_fail++;
      $display("FAIL reset_init: got c=%0b rem=%0d res=%0d, want all 0", carry_out, remainder, result);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    drive(16'd555, 16'd4350, 4'd0, 4'd0, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (dut.sel_r !== 4'd0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_edge1: got sel_r=%0d res=%0d, want sel_r=0 res=0", dut.sel_r, result);
    end
    drive(16'hFFFF, 16'd2, 4'd0, 4'd2, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (result !== 32'd4905 || carry_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_latency: got res=%0d c=%0b, want 4905 c=0", result, carry_out);
    end
    n_cmp++;
    if (dut.sel_r !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_selr_mul: got sel_r=%0d, want 2", dut.sel_r);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({carry_out, remainder, result} !== 49'd0 || dut.sel_r !== 4'd0 || dut.A_r !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_inflight: got c=%0b rem=%0d res=%0d sel_r=%0d A_r=%0d, want all 0",
               carry_out, remainder, result, dut.sel_r, dut.A_r);
    end
    drive(16'h0, 16'h0, 4'h0, 4'd15, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_flush: got res=%0d, want 0 (mul discarded)", result);
    end
  endtask

  task automatic test_addsub();
    logic [15:0] ta [6] = '{16'd60000, 16'hFFFF, 16'h0FFF, 16'd5000, 16'd3000, 16'd1000};
    logic [15:0] tb [6] = '{16'd1234,  16'd1,    16'd1,    16'd1234, 16'd3000, 16'd2000};
    logic [3:0]  ts [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
    logic        tc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] er [6] = '{32'd61234, 32'd0, 32'd4096, 32'd3766, 32'd0, 32'd64536};
    logic        ec [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], 4'd0, ts[i], tc[i]);
      n_cmp++;
      if ({carry_out, remainder, result} !== {ec[i], 16'd0, er[i]}) begin
        n_fail++;
        $display("FAIL addsub[%0d]: got c=%0b rem=%0d res=%0d, want c=%0b rem=0 res=%0d",
                 i, carry_out, remainder, result, ec[i], er[i]);
      end
    end
  endtask

  task automatic test_muldiv();
    logic [15:0] ta [6] = '{16'd25, 16'd255, 16'hFFFF, 16'd20, 16'd20, 16'd100};
    logic [15:0] tb [6] = '{16'd4,  16'd255, 16'd2,    16'd5,  16'd6,  16'd0};
    logic [3:0]  ts [6] = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3};
    logic [31:0] er [6] = '{32'd100, 32'd65025, 32'd131070, 32'd4, 32'd3, 32'h0000FFFF};
    logic [15:0] em [6] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd100};
    logic        ec [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], 4'd0, ts[i], 1'b1);
      n_cmp++;
      if ({carry_out, remainder, result} !== {ec[i], em[i], er[i]}) begin
        n_fail++;
        $display("FAIL muldiv[%0d]: got c=%0b rem=%0d res=%0d, want c=%0b rem=%0d res=%0d",
                 i, carry_out, remainder, result, ec[i], em[i], er[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [3:0]  ts [8] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd4, 4'd5, 4'd6, 4'd7};
    logic [3:0]  th [8] = '{4'd1, 4'd4, 4'd1, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [15:0] er [8] = '{16'h2002, 16'h0900, 16'h2003, 16'h1900,
                            16'h9001, 16'h9001, 16'h9001, 16'h9001};
    logic        ec [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_op(16'h9001, 16'hFFFF, th[i], ts[i], 1'b1);
      n_cmp++;
      if ({carry_out, remainder, result} !== {ec[i], 16'd0, 16'd0, er[i]}) begin
        n_fail++;
        $display("FAIL shift[%0d]: got c=%0b rem=%0d res=%h, want c=%0b rem=0 res=%h",
                 i, carry_out, remainder, result, ec[i], er[i]);
      end
    end
  endtask

  task automatic test_incdec_logic();
    logic [15:0] ta [9] = '{16'd10, 16'hFFFF, 16'd10, 16'd0, 16'hF0F0, 16'hF0F0, 16'hF0F0,
                            16'hF0F0, 16'hF0F0};
    logic [3:0]  ts [9] = '{4'd8, 4'd8, 4'd9, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
    logic [15:0] er [9] = '{16'd11, 16'd0, 16'd9, 16'd65535, 16'h00F0, 16'hFFF0, 16'hFF00,
                            16'h0F0F, 16'h0000};
    logic        ec [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      do_op(ta[i], 16'h0FF0, 4'd7, ts[i], 1'b1);
      n_cmp++;
      if ({carry_out, remainder, result} !== {ec[i], 16'd0, 16'd0, er[i]}) begin
        n_fail++;
        $display("FAIL incdec_logic[%0d]: got c=%0b rem=%0d res=%h, want c=%0b rem=0 res=%h",
                 i, carry_out, remainder, result, ec[i], er[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta [3] = '{16'd555, 16'd255, 16'd20};
    logic [15:0] tb [3] = '{16'd4350, 16'd255, 16'd6};
    logic [3:0]  ts [3] = '{4'd0, 4'd2, 4'd3};
    logic [48:0] ev [3] = '{{1'b0, 16'd0, 32'd4905}, {1'b0, 16'd0, 32'd65025},
                            {1'b0, 16'd2, 32'd3}};
    for (int j = 0; j < 5; j++) begin
      if (j < 3) drive(ta[j], tb[j], 4'd0, ts[j], 1'b0);
      else       drive(16'h0, 16'h0, 4'd0, 4'd15, 1'b0);
      @(posedge clk); #1;
      if (j >= 1 && j <= 3) begin
        n_cmp++;
        if ({carry_out, remainder, result} !== ev[j-1]) begin
          n_fail++;
          $display("FAIL back_to_back[%0d]: got %h, want %h", j-1,
                   {carry_out, remainder, result}, ev[j-1]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [48:0] exp_q [$];
    logic [48:0] e;
    logic [15:0] a, b;
    logic [3:0]  sh, op;
    logic        ci;
    int          n = 300;
    for (int j = 0; j <= n; j++) begin
      if (j < n) begin
        a  = 16'($urandom);
        b  = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
        if ($urandom_range(0, 9) == 0) a = 16'hFFFF;
        sh = 4'($urandom);
        op = 4'($urandom);
        ci = 1'($urandom);
        drive(a, b, sh, op, ci);
        model(a, b, sh, op, ci, e);
        exp_q.push_back(e);
      end else drive(16'h0, 16'h0, 4'd0, 4'd15, 1'b0);
      @(posedge clk); #1;
      if (j >= 1) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({carry_out, remainder, result} !== e) begin
          n_fail++;
          $display("FAIL random[%0d]: got c=%0b rem=%h res=%h, want c=%0b rem=%h res=%h",
                   j-1, carry_out, remainder, result, e[48], e[47:32], e[31:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_muldiv();
    test_shift();
    test_incdec_logic();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
